// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter giving NCORES requesters serialized access to one single-port RAM.
// Latency: write ack 2 cycles / read ack 2+RD_LAT cycles after grant; losers hold req (no loss), one idle cycle between transactions.
module mem_arbiter_rr #(
    parameter int NCORES = 3,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    ack,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren,
    input  logic [DW-1:0]        ram_q
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_last;
    logic [IW-1:0]     w_sel;
    logic [NCORES-1:0] w_sel_oh;
    logic              w_any;
    logic              w_wait_done;
    logic [NCORES-1:0] r_gnt;
    logic              r_we;
    logic              r_wren;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_din;
    logic [DW-1:0]     r_rdata;
    logic [CW-1:0]     r_wcnt;

    // Search starts one past the last winner so every requester is reached within NCORES-1 grants.
    always_comb begin
        w_sel = r_last;
        w_any = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            if (!w_any && req[(int'(r_last) + k) % NCORES]) begin
                w_sel = IW'((int'(r_last) + k) % NCORES);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_oh        = '0;
        w_sel_oh[w_sel] = 1'b1;
    end

    assign w_wait_done = (r_wcnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = r_we ? S_ACK : S_WAIT;
            S_WAIT:   if (w_wait_done) w_state_nxt = S_ACK;
            S_ACK:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Everything the transaction needs is captured on the grant edge; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_rdata <= '0;
            r_wcnt  <= '0;
            r_last  <= IW'(NCORES - 1);
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt  <= w_sel_oh;
                        r_addr <= addr[int'(w_sel)*AW +: AW];
                        r_din  <= wdata[int'(w_sel)*DW +: DW];
                        r_we   <= we[w_sel];
                        r_wren <= we[w_sel];
                        r_last <= w_sel;
                    end
                end
                S_ACCESS: begin
                    r_wcnt <= CW'(RD_LAT - 1);
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_rdata <= ram_q;
                    end else begin
                        r_wcnt <= r_wcnt - CW'(1);
                    end
                end
                S_ACK: begin
                    r_gnt <= '0;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign ack      = (r_state == S_ACK) ? r_gnt : '0;
    assign busy     = (r_state != S_IDLE);
    assign rdata    = r_rdata;
    assign ram_addr = r_addr;
    assign ram_din  = r_din;
    assign ram_wren = r_wren;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios plus random multi-core traffic against a transaction-level model.
module tb_mem_arbiter_rr;

    localparam int N   = 3;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int RDL = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req, we, gnt, ack;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, ram_din, ram_q;
    logic            busy, ram_wren;
    logic [AW-1:0]   ram_addr;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.NCORES(N), .AW(AW), .DW(DW), .RD_LAT(RDL)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // RAM with RDL-cycle read latency; the pre_* port only loads contents while in reset
    logic [DW-1:0] ram [256];
    logic [DW-1:0] q_pipe [RDL];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a  = '0;
    logic [DW-1:0] pre_d  = '0;

    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (ram_wren) ram[ram_addr] <= ram_din;
        q_pipe[0] <= ram[ram_addr];
        for (int i = 1; i < RDL; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign ram_q = q_pipe[RDL-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // per-core requester state
    logic [N-1:0]  c_req, c_we;
    logic [AW-1:0] c_addr [N];
    logic [DW-1:0] c_din  [N];
    bit            auto_drop;

    // transaction-level model
    int            cyc;
    bit            m_act;
    int            m_core, m_start, m_ack, m_last;
    bit            m_we;
    logic [AW-1:0] m_raddr;
    logic [DW-1:0] m_din, m_rdata;
    logic [DW-1:0] mmem [256];
    logic [N-1:0]  ack_log [$];

    task automatic model_reset();
        m_act   = 1'b0;
        m_last  = N - 1;
        m_raddr = '0;
        m_din   = '0;
        m_rdata = '0;
    endtask

    task automatic drive_vectors();
        req = c_req;
        we  = c_we;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = c_addr[i];
            wdata[i*DW +: DW] = c_din[i];
        end
    endtask

    // Decide what the arbiter accepts at the edge ending the current cycle.
    task automatic model_sample();
        int pick;
        if (rst) return;
        if (m_act && cyc <= m_ack) return;
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            if (pick < 0 && c_req[(m_last + k) % N]) pick = (m_last + k) % N;
        end
        if (pick < 0) return;
        m_act   = 1'b1;
        m_core  = pick;
        m_we    = c_we[pick];
        m_raddr = c_addr[pick];
        m_din   = c_din[pick];
        m_start = cyc + 1;
        m_ack   = cyc + (m_we ? 2 : 2 + RDL);
        m_last  = pick;
    endtask

    task automatic check_outputs();
        bit inw;
        inw = m_act && cyc >= m_start && cyc <= m_ack;
        if (m_act && cyc == m_ack) begin
            if (m_we) mmem[m_raddr] = m_din;
            else      m_rdata = mmem[m_raddr];
        end
        chk("busy",     32'(busy),     32'(inw));
        chk("gnt",      32'(gnt),      inw ? (32'd1 << m_core) : 32'd0);
        chk("ack",      32'(ack),      (m_act && cyc == m_ack) ? (32'd1 << m_core) : 32'd0);
        chk("ram_wren", 32'(ram_wren), 32'(m_act && m_we && cyc == m_start));
        chk("ram_addr", 32'(ram_addr), 32'(m_raddr));
        chk("ram_din",  32'(ram_din),  32'(m_din));
        chk("rdata",    32'(rdata),    32'(m_rdata));
        if (ack != '0) ack_log.push_back(ack);
    endtask

    task automatic tick();
        drive_vectors();
        model_sample();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        if (auto_drop) begin
            for (int i = 0; i < N; i++) if (ack[i]) c_req[i] = 1'b0;
        end
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        int b;
        b = budget;
        while (ack_log.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk(tag, 32'(ack_log.size()), 32'(n));
    endtask

    task automatic chk_order(input string tag, input int k, input logic [N-1:0] exp);
        chk(tag, 32'((k < ack_log.size()) ? ack_log[k] : '0), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        auto_drop = 1'b1;
        c_req = '0;
        c_we  = '0;
        for (int i = 0; i < N; i++) begin
            c_addr[i] = '0;
            c_din[i]  = '0;
        end
        drive_vectors();
        model_reset();

        // preload RAM and model while reset is held
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            pre_we = 1'b1;
            pre_a  = 8'(a);
            pre_d  = (a == 'h40) ? 8'h3C : 8'($urandom);
            mmem[a] = pre_d;
        end
        @(negedge clk);
        pre_we = 1'b0;
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // single write, granted on the first edge after reset release
        c_req = 3'b001; c_we = 3'b001; c_addr[0] = 8'h12; c_din[0] = 8'hA5;
        tick();
        chk("w1_addr", 32'(ram_addr), 32'h12);
        chk("w1_din",  32'(ram_din),  32'hA5);
        chk("w1_wren", 32'(ram_wren), 32'd1);
        tick();
        chk("w1_ack",  32'(ack),      32'b001);
        chk("w1_wren_off", 32'(ram_wren), 32'd0);
        tick();

        // single read from core 1
        c_req = 3'b010; c_we = 3'b000; c_addr[1] = 8'h40;
        tick();
        chk("r1_gnt", 32'(gnt), 32'b010);
        tick();
        chk("r1_ack_early", 32'(ack), 32'd0);
        tick();
        chk("r1_ack",   32'(ack),   32'b010);
        chk("r1_rdata", 32'(rdata), 32'h3C);
        tick();

        // inputs changed right after grant must not reach the RAM
        c_req = 3'b001; c_we = 3'b001; c_addr[0] = 8'h21; c_din[0] = 8'h5A;
        tick();
        c_addr[0] = 8'h99; c_din[0] = 8'h00; c_we[0] = 1'b0;
        tick();
        chk("stab_addr", 32'(ram_addr), 32'h21);
        chk("stab_din",  32'(ram_din),  32'h5A);
        tick();
        c_req = 3'b001; c_we = 3'b000; c_addr[0] = 8'h21;
        ack_log.delete();
        wait_acks("stab_rd_wait", 1, 10);
        chk("stab_rdata", 32'(rdata), 32'h5A);
        tick();

        // reset during a write's ACCESS cycle
        c_req = 3'b001; c_we = 3'b001; c_addr[0] = 8'h30; c_din[0] = 8'h77;
        tick();
        chk("rstw_wren_pre", 32'(ram_wren), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstw_wren", 32'(ram_wren), 32'd0);
        chk("rstw_gnt",  32'(gnt),      32'd0);
        chk("rstw_busy", 32'(busy),     32'd0);
        model_reset();
        c_req = '0;
        ack_log.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rstw_no_ack", 32'(ack_log.size()), 32'd0);

        // all cores request continuously
        auto_drop = 1'b0;
        c_req = 3'b111; c_we = 3'b000;
        c_addr[0] = 8'h30; c_addr[1] = 8'h02; c_addr[2] = 8'h03;
        wait_acks("cont_wait", 4, 60);
        c_req = '0;
        auto_drop = 1'b1;
        chk_order("cont_0", 0, 3'b001);
        chk_order("cont_1", 1, 3'b010);
        chk_order("cont_2", 2, 3'b100);
        chk_order("cont_3", 3, 3'b001);
        tick();

        // rotation with cores 0 and 2
        ack_log.delete();
        c_req = 3'b101;
        wait_acks("rot_wait_a", 2, 30);
        chk_order("rot_a0", 0, 3'b100);
        chk_order("rot_a1", 1, 3'b001);
        ack_log.delete();
        c_req = 3'b101;
        wait_acks("rot_wait_b", 1, 30);
        chk_order("rot_b0", 0, 3'b100);
        ack_log.delete();
        wait_acks("rot_wait_c", 1, 30);
        chk_order("rot_c0", 0, 3'b001);
        tick();

        // random traffic with late input changes and withdrawn requests
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (m_act && cyc >= m_start && cyc <= m_ack && i == m_core) begin
                    if ($urandom_range(0, 1) == 1) begin
                        c_we[i]   = 1'($urandom);
                        c_addr[i] = 8'($urandom);
                        c_din[i]  = 8'($urandom);
                    end
                end else if (!c_req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        c_req[i]  = 1'b1;
                        c_we[i]   = 1'($urandom);
                        c_addr[i] = 8'($urandom_range(0, 15));
                        c_din[i]  = 8'($urandom);
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    c_req[i] = 1'b0;
                end
            end
            tick();
        end

        begin
            int b;
            b = 20;
            while (m_act && cyc <= m_ack && b > 0) begin
                tick();
                b--;
            end
            chk("drain", 32'(m_act && cyc <= m_ack), 32'd0);
        end
        c_req = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Parameters
REQ-001 NCORES, default 3, number of requesting cores (2..8) SHALL be supported.
REQ-002 AW, default 8, RAM address width SHALL apply.
REQ-003 DW, default 8, RAM data width SHALL apply.
REQ-004 RD_LAT, default 1, RAM read latency in cycles (1..4) SHALL apply.

Interface
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req  in  NCORES  per-core access request, level, held until ack.
REQ-008 we  in  NCORES  per-core write enable (1 = write, 0 = read), qualified by req.
REQ-009 addr  in  NCORES*AW  packed addresses, core i at [i*AW +: AW].
REQ-010 wdata  in  NCORES*DW  packed write data, core i at [i*DW +: DW].
REQ-011 gnt  out  NCORES  one-hot grant, held from ACCESS through ACK.
REQ-012 ack  out  NCORES  one-cycle completion pulse to the granted core.
REQ-013 rdata  out  DW  read data, valid during the ack cycle of a read.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 ram_addr  out  AW  registered RAM address.
REQ-016 ram_din  out  DW  registered RAM write data.
REQ-017 ram_wren  out  1  registered RAM write strobe.
REQ-018 ram_q  in  DW  RAM read data.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, WAIT and ACK.
REQ-020 In IDLE with any req bit high, the arbiter SHALL grant the first requesting core searching from (last+1) mod NCORES upward, with wrap-around.
REQ-021 On the IDLE->ACCESS edge, the block SHALL register gnt, ram_addr, ram_din and the selected we, and SHALL set last to the granted index.
REQ-022 Changes to addr, wdata or we after the grant edge SHALL have no effect on the current transaction.
REQ-023 ACCESS SHALL last exactly 1 cycle, and ram_wren SHALL be 1 only in ACCESS of a write.
REQ-024 Write sequence SHALL be ACCESS->ACK, giving ack 2 cycles after the sampling edge.
REQ-025 Read sequence SHALL be ACCESS->WAIT for RD_LAT cycles->ACK, with ram_q captured into rdata on the edge ending the last WAIT cycle.
REQ-026 Read ack latency SHALL be 2+RD_LAT cycles after the sampling edge.
REQ-027 ACK SHALL last 1 cycle, then the FSM SHALL go to IDLE; there is one mandatory idle cycle between transactions.
REQ-028 The requester SHALL drop req on the edge after ack, and a req still high in IDLE SHALL be treated as a new request.
REQ-029 Non-granted req lines SHALL be held pending without loss, and req deasserted before grant SHALL be ignored.
REQ-030 rdata SHALL hold its last captured value outside read ACK, and is not updated on writes.
REQ-031 Simultaneous requests from all cores SHALL be served in rotating order with no core starved beyond NCORES-1 transactions.
REQ-032 The state encoding SHALL be independent of NCORES width.
REQ-033 ram_addr and ram_din SHALL hold their values outside ACCESS, and only ram_wren gates writes.

Reset
REQ-034 While rst=1, asynchronously: state=IDLE, gnt=0, ack=0, busy=0, ram_wren=0, ram_addr=0, ram_din=0, rdata=0, last=NCORES-1 (so core 0 wins first).
REQ-035 Reset asserted mid-transaction SHALL abort it immediately with no ack, and a write in ACCESS SHALL see ram_wren drop without waiting for the clock.
REQ-036 The first grant SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-037 Single write: req=001, we=001, addr0=0x12, wdata0=0xA5 -> next cycle ram_addr=0x12, ram_din=0xA5, ram_wren=1 for 1 cycle; ack=001 the following cycle.
REQ-038 Single read (RD_LAT=1, RAM holds 0x3C at 0x40): core1 req, addr1=0x40 -> gnt=010, ack=010 at cycle 3 with rdata=0x3C.
REQ-039 Contention: req=111 held continuously after reset -> grant order 0,1,2,0 with each ack one-hot and never overlapping.
REQ-040 Rotation: after core 2 is served, req=101 -> core 0 is granted next; after core 0 is served, req=101 -> core 2 is granted.
REQ-041 Reset mid-write: assert rst during ACCESS -> ram_wren=0 and gnt=0 before the next edge, and no ack is issued.
REQ-042 Input stability: change addr0 the cycle after grant -> the RAM sees the originally sampled address.
